// File: rtl/sync_fifo_param_if.sv
// Push/pop handshake and status bundle for sync_fifo_param.
// The producer/consumer side uses master; the FIFO uses slave.
interface sync_fifo_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             write_en;
    logic [WIDTH-1:0] data_in;
    logic             read_en;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write_en, data_in, read_en, err_clr,
        input  data_out, data_valid, full, empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en, err_clr,
        output data_out, data_valid, full, empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or fall-through reads,
// occupancy count, programmable almost flags and sticky error flags.
module sync_fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input logic clk,
    input logic async_rst,
    sync_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t DEPTH_C = ptr_t'(DEPTH);
    localparam ptr_t AF_C    = ptr_t'(AF_THRESH);
    localparam ptr_t AE_C    = ptr_t'(AE_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t count_q, count_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic af_q, af_d;
    logic ae_q, ae_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic push, pop;

    // Acceptance looks only at registered flags, never at the other port.
    assign push = bus.write_en && !full_q;
    assign pop  = bus.read_en && !empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + ptr_t'(1);
        if (pop)  rptr_d = rptr_q + ptr_t'(1);
        if (push && !pop)      count_d = count_q + ptr_t'(1);
        else if (pop && !push) count_d = count_q - ptr_t'(1);
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        // A new error in the same cycle as err_clr keeps the flag set.
        ovf_d = ovf_q && !bus.err_clr;
        unf_d = unf_q && !bus.err_clr;
        if (bus.write_en && full_q) ovf_d = 1'b1;
        if (bus.read_en && empty_q) unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out   = mem_q[rptr_q[AW-1:0]];
            assign bus.data_valid = !empty_q;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q, dout_d;
            logic             dval_q, dval_d;

            always_comb begin
                dout_d = dout_q;
                dval_d = pop;
                if (pop) dout_d = mem_q[rptr_q[AW-1:0]];
            end

            always_ff @(posedge clk or negedge async_rst) begin
                if (!async_rst) begin
                    dout_q <= '0;
                    dval_q <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dval_q <= dval_d;
                end
            end

            assign bus.data_out   = dout_q;
            assign bus.data_valid = dval_q;
        end
    endgenerate

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read and a fall-through
// instance, both DEPTH=4, WIDTH=8, almost_full at 3, almost_empty at 1.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic async_rst = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   mcount;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(4)) a ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(4)) b ();

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)
    ) u_std (
        .clk(clk), .async_rst(async_rst), .bus(a)
    );

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
    ) u_fwft (
        .clk(clk), .async_rst(async_rst), .bus(b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] v);
        a.write_en = 1'b1;
        a.data_in  = v;
        step();
        a.write_en = 1'b0;
    endtask

    task automatic pop_a(input logic [7:0] exp, input string tag);
        a.read_en = 1'b1;
        step();
        a.read_en = 1'b0;
        chk({tag, "_dv"}, 32'(a.data_valid), 32'd1);
        chk({tag, "_do"}, 32'(a.data_out), 32'(exp));
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_cnt"}, 32'(a.count), 32'(mcount));
        chk({tag, "_af"}, 32'(a.almost_full), 32'(mcount >= 3));
        chk({tag, "_ae"}, 32'(a.almost_empty), 32'(mcount <= 1));
    endtask

    initial begin
        a.write_en = 0; a.data_in = 0; a.read_en = 0; a.err_clr = 0;
        b.write_en = 0; b.data_in = 0; b.read_en = 0; b.err_clr = 0;
        step();
        step();
        chk("rst_cnt", 32'(a.count), 32'd0);
        chk("rst_empty", 32'(a.empty), 32'd1);
        chk("rst_full", 32'(a.full), 32'd0);
        chk("rst_ae", 32'(a.almost_empty), 32'd1);
        chk("rst_af", 32'(a.almost_full), 32'd0);
        chk("rst_dv", 32'(a.data_valid), 32'd0);
        chk("rst_do", 32'(a.data_out), 32'd0);
        chk("rst_fw_dv", 32'(b.data_valid), 32'd0);
        async_rst = 1'b1;
        step();

        // 1: fill and drain in order
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        chk("t1_af3", 32'(a.almost_full), 32'd1);
        chk("t1_nfull3", 32'(a.full), 32'd0);
        push_a(8'h44);
        chk("t1_full", 32'(a.full), 32'd1);
        chk("t1_cnt", 32'(a.count), 32'd4);
        pop_a(8'h11, "t1_p0");
        pop_a(8'h22, "t1_p1");
        pop_a(8'h33, "t1_p2");
        pop_a(8'h44, "t1_p3");
        step();
        chk("t1_dv0", 32'(a.data_valid), 32'd0);
        chk("t1_hold", 32'(a.data_out), 32'h44);
        chk("t1_empty", 32'(a.empty), 32'd1);

        // 2: overflow is rejected and sticky
        push_a(8'h01);
        push_a(8'h02);
        push_a(8'h03);
        push_a(8'h04);
        push_a(8'h55);
        chk("t2_ovf", 32'(a.overflow), 32'd1);
        chk("t2_cnt", 32'(a.count), 32'd4);
        pop_a(8'h01, "t2_p0");
        pop_a(8'h02, "t2_p1");
        pop_a(8'h03, "t2_p2");
        pop_a(8'h04, "t2_p3");
        chk("t2_empty", 32'(a.empty), 32'd1);
        chk("t2_ovf_hold", 32'(a.overflow), 32'd1);
        a.err_clr = 1'b1;
        step();
        a.err_clr = 1'b0;
        chk("t2_ovf_clr", 32'(a.overflow), 32'd0);

        // 3: pop+push on empty, then push+pop at count 2
        a.read_en = 1'b1;
        push_a(8'hA5);
        a.read_en = 1'b0;
        chk("t3_unf", 32'(a.underflow), 32'd1);
        chk("t3_cnt1", 32'(a.count), 32'd1);
        chk("t3_dv0", 32'(a.data_valid), 32'd0);
        pop_a(8'hA5, "t3_pa5");
        push_a(8'hB1);
        push_a(8'hB2);
        chk("t3_cnt2", 32'(a.count), 32'd2);
        a.read_en = 1'b1;
        push_a(8'hB3);
        a.read_en = 1'b0;
        chk("t3_both_cnt", 32'(a.count), 32'd2);
        chk("t3_both_do", 32'(a.data_out), 32'hB1);
        pop_a(8'hB2, "t3_pb2");
        pop_a(8'hB3, "t3_pb3");
        chk("t3_unf_hold", 32'(a.underflow), 32'd1);
        a.err_clr = 1'b1;
        a.read_en = 1'b1;
        step();
        a.err_clr = 1'b0;
        a.read_en = 1'b0;
        chk("t3_set_wins", 32'(a.underflow), 32'd1);
        a.err_clr = 1'b1;
        step();
        a.err_clr = 1'b0;
        chk("t3_unf_clr", 32'(a.underflow), 32'd0);

        // 4: wrap with per-cycle almost flag checks
        mcount = 0;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                push_a(8'(r * 3 + k));
                mcount++;
                chk_flags("t4_push");
            end
            for (int k = 0; k < 3; k++) begin
                pop_a(8'(r * 3 + k), "t4_pop");
                mcount--;
                chk_flags("t4_pop");
            end
        end
        chk("t4_empty", 32'(a.empty), 32'd1);

        // 5: fall-through shows head before any read_en
        b.write_en = 1'b1;
        b.data_in  = 8'h7E;
        chk("t5_dv_pre", 32'(b.data_valid), 32'd0);
        step();
        b.write_en = 1'b0;
        chk("t5_dv", 32'(b.data_valid), 32'd1);
        chk("t5_do", 32'(b.data_out), 32'h7E);
        step();
        chk("t5_dv_keep", 32'(b.data_valid), 32'd1);
        b.read_en = 1'b1;
        step();
        b.read_en = 1'b0;
        chk("t5_dv_off", 32'(b.data_valid), 32'd0);
        chk("t5_empty", 32'(b.empty), 32'd1);

        // 6: asynchronous reset mid-cycle
        push_a(8'hC1);
        push_a(8'hC2);
        push_a(8'hC3);
        pop_a(8'hC1, "t6_pre");
        push_a(8'hC4);
        chk("t6_cnt3", 32'(a.count), 32'd3);
        a.write_en = 1'b1;
        a.data_in  = 8'hEE;
        a.read_en  = 1'b1;
        #2;
        async_rst = 1'b0;
        #1;
        chk("t6_cnt", 32'(a.count), 32'd0);
        chk("t6_empty", 32'(a.empty), 32'd1);
        chk("t6_full", 32'(a.full), 32'd0);
        chk("t6_af", 32'(a.almost_full), 32'd0);
        chk("t6_ae", 32'(a.almost_empty), 32'd1);
        chk("t6_dv", 32'(a.data_valid), 32'd0);
        chk("t6_do", 32'(a.data_out), 32'd0);
        chk("t6_ovf", 32'(a.overflow), 32'd0);
        chk("t6_unf", 32'(a.underflow), 32'd0);
        a.write_en = 1'b0;
        a.read_en  = 1'b0;
        step();
        async_rst = 1'b1;
        step();
        push_a(8'h01);
        chk("t6_cnt_new", 32'(a.count), 32'd1);
        pop_a(8'h01, "t6_new");
        step();
        chk("t6_empty_end", 32'(a.empty), 32'd1);
        chk("t6_unf_end", 32'(a.underflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
